// File: rtl/proc_isa_pkg.sv
// Shared ISA definitions for the pipeline control blocks: opcodes, ALU
// function codes, forwarding select encoding and register decode helpers.
package proc_isa_pkg;

  typedef enum logic [4:0] {
    OP_ALU  = 5'd0,
    OP_BNE  = 5'd2,
    OP_JAL  = 5'd3,
    OP_JR   = 5'd4,
    OP_ADDI = 5'd5,
    OP_BLT  = 5'd6,
    OP_SW   = 5'd7,
    OP_LW   = 5'd8,
    OP_SETX = 5'd21,
    OP_BEX  = 5'd22
  } opcode_e;

  typedef enum logic [4:0] {
    ALU_MUL = 5'd6,
    ALU_DIV = 5'd7
  } alu_op_e;

  typedef enum logic [1:0] {
    FWD_RF  = 2'd0,
    FWD_XM  = 2'd1,
    FWD_WB  = 2'd2,
    FWD_ERR = 2'd3
  } fwd_sel_e;

  localparam int ERR_REG_DEFAULT  = 30;
  localparam int LINK_REG_DEFAULT = 31;

  // A register reference that may be absent (valid = 0).
  typedef struct packed {
    logic       valid;
    logic [4:0] idx;
  } reg_ref_t;

  function automatic opcode_e op_of(input logic [31:0] instr);
    return opcode_e'(instr[31:27]);
  endfunction

  function automatic logic [4:0] rd_of(input logic [31:0] instr);
    return instr[26:22];
  endfunction

  // Destination register written by an instruction; r0 never counts.
  function automatic reg_ref_t dest_of(input logic [31:0] instr,
                                       input logic [4:0]  err_reg,
                                       input logic [4:0]  link_reg);
    reg_ref_t r;
    r = '{valid: 1'b0, idx: 5'd0};
    case (op_of(instr))
      OP_ALU, OP_ADDI, OP_LW: r = '{valid: 1'b1, idx: instr[26:22]};
      OP_JAL:                 r = '{valid: 1'b1, idx: link_reg};
      OP_SETX:                r = '{valid: 1'b1, idx: err_reg};
      default:                r = '{valid: 1'b0, idx: 5'd0};
    endcase
    if (r.idx == 5'd0) r.valid = 1'b0;
    return r;
  endfunction

  // Source register read on operand port 0 (A), 1 (B) or 2 (C, store data).
  function automatic reg_ref_t src_of(input logic [31:0] instr,
                                      input int          port,
                                      input logic [4:0]  err_reg);
    reg_ref_t r;
    r = '{valid: 1'b0, idx: 5'd0};
    if (port == 0) begin
      case (op_of(instr))
        OP_ALU, OP_ADDI, OP_SW, OP_LW: r = '{valid: 1'b1, idx: instr[21:17]};
        OP_BNE, OP_JR, OP_BLT:         r = '{valid: 1'b1, idx: instr[26:22]};
        OP_BEX:                        r = '{valid: 1'b1, idx: err_reg};
        default:                       r = '{valid: 1'b0, idx: 5'd0};
      endcase
    end else if (port == 1) begin
      case (op_of(instr))
        OP_ALU:         r = '{valid: 1'b1, idx: instr[16:12]};
        OP_BNE, OP_BLT: r = '{valid: 1'b1, idx: instr[21:17]};
        default:        r = '{valid: 1'b0, idx: 5'd0};
      endcase
    end else if (port == 2) begin
      if (op_of(instr) == OP_SW) r = '{valid: 1'b1, idx: instr[26:22]};
    end
    return r;
  endfunction

  function automatic logic is_multdiv(input logic [31:0] instr);
    return (op_of(instr) == OP_ALU) &&
           ((instr[6:2] == ALU_MUL) || (instr[6:2] == ALU_DIV));
  endfunction

endpackage

// File: rtl/md_scoreboard.sv
// Tracks the single multdiv operation in flight: busy flag, destination
// register and a down-counter that flags the result cycle.
module md_scoreboard
  import proc_isa_pkg::*;
#(
  parameter int MD_CYCLES = 32
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       md_start,
  input  logic [4:0] start_dest,
  output logic       md_busy,
  output logic       md_done,
  output logic [4:0] md_dest
);

  localparam logic [5:0] MD_LOAD = 6'(MD_CYCLES - 1);

  logic       busy_d, busy_q;
  logic [4:0] dest_d, dest_q;
  logic [5:0] count_d, count_q;

  // Launch loads the counter; a busy op counts down and retires at zero.
  always_comb begin
    busy_d  = busy_q;
    dest_d  = dest_q;
    count_d = count_q;
    if (busy_q) begin
      if (count_q == 6'd0) begin
        busy_d = 1'b0;
      end else begin
        count_d = count_q - 6'd1;
      end
    end else if (md_start) begin
      busy_d  = 1'b1;
      dest_d  = start_dest;
      count_d = MD_LOAD;
    end
  end

  // State register; reset abandons any operation in flight.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      busy_q  <= 1'b0;
      dest_q  <= 5'd0;
      count_q <= 6'd0;
    end else begin
      busy_q  <= busy_d;
      dest_q  <= dest_d;
      count_q <= count_d;
    end
  end

  assign md_busy = busy_q;
  assign md_dest = dest_q;
  assign md_done = busy_q && (count_q == 6'd0);

endmodule

// File: rtl/hazard_forward_ctrl.sv
// Pipeline hazard unit: operand forwarding selects for DX, load-use and
// multdiv interlocks, and launch control for the iterative multdiv.
module hazard_forward_ctrl
  import proc_isa_pkg::*;
#(
  parameter int NUM_PORTS = 2,
  parameter int MD_CYCLES = 32,
  parameter int ERR_REG   = ERR_REG_DEFAULT,
  parameter int LINK_REG  = LINK_REG_DEFAULT
) (
  input  logic                   clock,
  input  logic                   reset,
  input  logic [31:0]            fd_instr,
  input  logic [31:0]            dx_instr,
  input  logic [31:0]            xm_instr,
  input  logic [31:0]            wb_instr,
  input  logic                   xm_err,
  input  logic                   wb_err,
  output logic [2*NUM_PORTS-1:0] fwd_sel,
  output logic                   stall_fd,
  output logic                   bubble_dx,
  output logic                   md_start,
  output logic                   md_busy,
  output logic                   md_done,
  output logic [4:0]             md_dest
);

  localparam logic [4:0] ERR_IDX  = 5'(ERR_REG);
  localparam logic [4:0] LINK_IDX = 5'(LINK_REG);

  reg_ref_t xm_dest;
  reg_ref_t wb_dest;
  logic     load_use;
  logic     md_hazard;
  logic     stall;

  assign xm_dest = dest_of(xm_instr, ERR_IDX, LINK_IDX);
  assign wb_dest = dest_of(wb_instr, ERR_IDX, LINK_IDX);

  // Per-port operand select: exception value, then youngest producer.
  always_comb begin
    fwd_sel = '0;
    for (int p = 0; p < NUM_PORTS; p++) begin
      reg_ref_t src;
      fwd_sel_e sel;
      src = src_of(dx_instr, p, ERR_IDX);
      sel = FWD_RF;
      if (src.valid) begin
        if ((src.idx == ERR_IDX) && (xm_err || wb_err)) begin
          sel = FWD_ERR;
        end else if (xm_dest.valid && (xm_dest.idx == src.idx)) begin
          sel = FWD_XM;
        end else if (wb_dest.valid && (wb_dest.idx == src.idx)) begin
          sel = FWD_WB;
        end
      end
      fwd_sel[2*p +: 2] = sel;
    end
  end

  // Interlock detection: FD reading a load in DX or the pending multdiv result.
  always_comb begin
    load_use  = 1'b0;
    md_hazard = is_multdiv(fd_instr);
    for (int p = 0; p < NUM_PORTS; p++) begin
      reg_ref_t src;
      src = src_of(fd_instr, p, ERR_IDX);
      if (src.valid && (op_of(dx_instr) == OP_LW) &&
          (rd_of(dx_instr) != 5'd0) && (src.idx == rd_of(dx_instr))) begin
        load_use = 1'b1;
      end
      if (src.valid && (md_dest != 5'd0) && (src.idx == md_dest)) begin
        md_hazard = 1'b1;
      end
    end
  end

  // Both interlock causes collapse onto one stall/bubble pair.
  assign stall     = !reset && (load_use || (md_busy && md_hazard));
  assign stall_fd  = stall;
  assign bubble_dx = stall;
  assign md_start  = !reset && !md_busy && is_multdiv(dx_instr);

  md_scoreboard #(
    .MD_CYCLES (MD_CYCLES)
  ) u_md_scoreboard (
    .clock      (clock),
    .reset      (reset),
    .md_start   (md_start),
    .start_dest (rd_of(dx_instr)),
    .md_busy    (md_busy),
    .md_done    (md_done),
    .md_dest    (md_dest)
  );

endmodule
